// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types: default register-file geometry,
// register-address and data-word typedefs, and the hardwired-zero register index.
package mips_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int DEPTH_DEF  = 32;
  localparam int NUM_RD_DEF = 2;
  localparam int AW_DEF     = $clog2(DEPTH_DEF);

  typedef logic [AW_DEF-1:0]    reg_addr_t;
  typedef logic [WIDTH_DEF-1:0] word_t;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_sb_if.sv
// Register-file bus: writeback port, issue port and NUM_RD read ports.
// No handshake: every cycle the master presents one write, one issue and NUM_RD
// read addresses; the slave answers reads combinationally in the same cycle.
interface regfile_sb_if
  import mips_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NUM_RD = NUM_RD_DEF
);
  localparam int AW = $clog2(DEPTH);

  logic                    regW;
  logic [AW-1:0]           DR;
  logic [WIDTH-1:0]        regIn;
  logic [NUM_RD*AW-1:0]    rd_addr;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]       rd_busy;
  logic                    iss_valid;
  logic [AW-1:0]           iss_dr;

  modport master (
    output regW, DR, regIn, rd_addr, iss_valid, iss_dr,
    input  rd_data, rd_busy
  );

  modport slave (
    input  regW, DR, regIn, rd_addr, iss_valid, iss_dr,
    output rd_data, rd_busy
  );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback, set wins on a
// same-register collision. Register 0 is never busy.
module regfile_sb_scoreboard
  import mips_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NUM_RD = NUM_RD_DEF,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en_i,
  input  logic [AW-1:0]        set_addr_i,
  input  logic                 clr_en_i,
  input  logic [AW-1:0]        clr_addr_i,
  input  logic [NUM_RD*AW-1:0] rd_addr_i,
  output logic [NUM_RD-1:0]    rd_busy_o
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Clear first so a newer producer issuing to the same register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
    if (set_en_i) busy_d[set_addr_i] = 1'b1;
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  always_comb begin
    rd_busy_o = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_busy_o[p] = busy_q[rd_addr_i[p*AW +: AW]];
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised MIPS register file with busy scoreboard. Defining
// REGFILE_BYPASS_EN forwards same-cycle writeback data to matching read ports.
module regfile_sb
  import mips_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_sb_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  logic                    wr_en;
  logic                    iss_en;
  logic [WIDTH-1:0]        regs_q [1:DEPTH-1];
  logic [AW-1:0]           port_addr [NUM_RD];
  logic [NUM_RD-1:0]       sb_busy;
  logic [NUM_RD*WIDTH-1:0] rd_data_c;
  logic [NUM_RD-1:0]       rd_busy_c;

  assign wr_en  = bus.regW      && (bus.DR     != AW'(REG_ZERO));
  assign iss_en = bus.iss_valid && (bus.iss_dr != AW'(REG_ZERO));

  for (genvar p = 0; p < NUM_RD; p++) begin : g_addr
    assign port_addr[p] = bus.rd_addr[p*AW +: AW];
  end

  // Register 0 has no storage; it is synthesised as a constant zero on read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < DEPTH; r++) regs_q[r] <= '0;
    end else if (wr_en) begin
      for (int r = 1; r < DEPTH; r++) begin
        if (bus.DR == AW'(r)) regs_q[r] <= bus.regIn;
      end
    end
  end

  regfile_sb_scoreboard #(
    .DEPTH  (DEPTH),
    .NUM_RD (NUM_RD),
    .AW     (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en_i   (iss_en),
    .set_addr_i (bus.iss_dr),
    .clr_en_i   (wr_en),
    .clr_addr_i (bus.DR),
    .rd_addr_i  (bus.rd_addr),
    .rd_busy_o  (sb_busy)
  );

  always_comb begin
    rd_data_c = '0;
    rd_busy_c = sb_busy;
    for (int p = 0; p < NUM_RD; p++) begin
      for (int r = 1; r < DEPTH; r++) begin
        if (port_addr[p] == AW'(r)) rd_data_c[p*WIDTH +: WIDTH] = regs_q[r];
      end
`ifdef REGFILE_BYPASS_EN
      // Forwarded data is current, so busy reads 0 even if a new issue targets it.
      if (rst_n && wr_en && (port_addr[p] == bus.DR)) begin
        rd_data_c[p*WIDTH +: WIDTH] = bus.regIn;
        rd_busy_c[p]                = 1'b0;
      end
`else
`endif
    end
  end

  assign bus.rd_data = rd_data_c;
  assign bus.rd_busy = rd_busy_c;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb (WIDTH=16, DEPTH=8, NUM_RD=4): the driver pushes
// expected read responses from an array model, a negedge monitor pops and compares.
module tb_regfile_sb;
  import mips_pkg::*;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int N  = 4;
  localparam int A  = 3;
  localparam int EW = N*W + N;

  logic clk;
  logic rst_n;

  regfile_sb_if #(.WIDTH(W), .DEPTH(D), .NUM_RD(N)) bus ();

  regfile_sb #(.WIDTH(W), .DEPTH(D), .NUM_RD(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // reference model
  logic [W-1:0] m_reg [D];
  logic         m_busy [D];

  logic [EW-1:0] exp_q [$];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            mon_cyc  = 0;

  task automatic model_clear();
    for (int r = 0; r < D; r++) begin
      m_reg[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  // Apply what the register file should have absorbed at the edge just seen.
  task automatic model_edge();
    if (!rst_n) begin
      model_clear();
    end else begin
      if (bus.regW && bus.DR != 0) begin
        m_reg[bus.DR]  = bus.regIn;
        m_busy[bus.DR] = 1'b0;
      end
      if (bus.iss_valid && bus.iss_dr != 0) m_busy[bus.iss_dr] = 1'b1;
    end
  endtask

  task automatic push_expected();
    logic [EW-1:0] e;
    logic [A-1:0]  a;
    logic [W-1:0]  d;
    logic          b;
    e = '0;
    for (int p = 0; p < N; p++) begin
      a = bus.rd_addr[p*A +: A];
      d = (a == 0) ? '0 : m_reg[a];
      b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
      if (rst_n && bus.regW && bus.DR != 0 && a == bus.DR) begin
        d = bus.regIn;
        b = 1'b0;
      end
`endif
      e[p*W +: W] = d;
      e[N*W + p]  = b;
    end
    exp_q.push_back(e);
  endtask

  // driver
  task automatic step(input logic rst, input logic w, input logic [A-1:0] dr,
                      input logic [W-1:0] din, input logic [N*A-1:0] ra,
                      input logic iv, input logic [A-1:0] idr);
    @(posedge clk);
    model_edge();
    #1;
    rst_n         = rst;
    if (!rst) model_clear();
    bus.regW      = w;
    bus.DR        = dr;
    bus.regIn     = din;
    bus.rd_addr   = ra;
    bus.iss_valid = iv;
    bus.iss_dr    = idr;
    push_expected();
  endtask

  function automatic logic [N*A-1:0] ra4(input logic [A-1:0] a0, input logic [A-1:0] a1,
                                         input logic [A-1:0] a2, input logic [A-1:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  // monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int p = 0; p < N; p++) begin
        n_checks++;
        if (bus.rd_data[p*W +: W] === e[p*W +: W]) n_pass++;
        else $display("FAIL port%0d_data cyc=%0d got=%h exp=%h", p, mon_cyc,
                      bus.rd_data[p*W +: W], e[p*W +: W]);
        n_checks++;
        if (bus.rd_busy[p] === e[N*W + p]) n_pass++;
        else $display("FAIL port%0d_busy cyc=%0d got=%b exp=%b", p, mon_cyc,
                      bus.rd_busy[p], e[N*W + p]);
      end
      mon_cyc++;
    end
  end

  // stimulus
  initial begin
    word_t     unused_word;
    reg_addr_t unused_addr;
    unused_word   = '0;
    unused_addr   = '0;
    rst_n         = 1'b0;
    bus.regW      = 1'b0;
    bus.DR        = '0;
    bus.regIn     = '0;
    bus.rd_addr   = '0;
    bus.iss_valid = 1'b0;
    bus.iss_dr    = '0;
    model_clear();

    // reset state, with write/issue attempts ignored
    step(0, 0, 0, 0,       ra4(0, 1, 2, 3), 0, 0);
    step(0, 1, 2, 16'h77,  ra4(2, 2, 2, 2), 1, 2);
    // write / read, reg 0 hardwired
    step(1, 1, 1, 16'd200, ra4(0, 1, 0, 0), 0, 0);
    step(1, 0, 0, 16'd0,   ra4(0, 1, 0, 0), 0, 0);
    step(1, 1, 0, 16'd5,   ra4(0, 0, 0, 0), 0, 0);
    step(1, 0, 0, 16'd0,   ra4(0, 0, 0, 0), 0, 0);
    // multi-port
    step(1, 1, 3, 16'hA,   ra4(0, 0, 0, 0), 0, 0);
    step(1, 1, 7, 16'hB,   ra4(0, 0, 0, 0), 0, 0);
    step(1, 0, 0, 16'h0,   ra4(3, 7, 3, 0), 0, 0);
    // scoreboard set, clear, set-wins, different registers
    step(1, 0, 0, 16'h0,   ra4(6, 6, 0, 5), 1, 6);
    step(1, 0, 0, 16'h0,   ra4(6, 6, 0, 5), 0, 0);
    step(1, 1, 6, 16'h55,  ra4(6, 0, 6, 5), 0, 0);
    step(1, 0, 0, 16'h0,   ra4(6, 0, 6, 5), 1, 6);
    step(1, 1, 6, 16'h66,  ra4(6, 6, 6, 6), 1, 6);
    step(1, 1, 6, 16'h67,  ra4(6, 5, 6, 5), 1, 5);
    step(1, 0, 0, 16'h0,   ra4(6, 5, 0, 0), 0, 0);
    // forwarding case
    step(1, 1, 4, 16'd7,   ra4(4, 0, 0, 0), 1, 4);
    step(1, 1, 4, 16'd99,  ra4(4, 4, 4, 4), 0, 0);
    step(1, 0, 0, 16'd0,   ra4(4, 4, 4, 4), 0, 0);
    step(1, 1, 2, 16'h31,  ra4(2, 2, 0, 0), 1, 2);
    // full-width data, reg 0 write ignored
    step(1, 1, 7, 16'hFFFF, ra4(7, 0, 0, 0), 0, 0);
    step(1, 1, 0, 16'hFFFF, ra4(7, 0, 7, 0), 0, 0);
    step(1, 0, 0, 16'h0,    ra4(7, 0, 7, 0), 0, 0);
    // reset mid-run during a write
    step(1, 1, 5, 16'h1234, ra4(5, 0, 0, 0), 1, 3);
    step(1, 0, 0, 16'h0,    ra4(5, 3, 7, 6), 0, 0);
    step(0, 1, 5, 16'h4321, ra4(5, 3, 7, 6), 1, 5);
    step(1, 0, 0, 16'h0,    ra4(5, 3, 7, 6), 0, 0);
    step(1, 0, 0, 16'h0,    ra4(5, 3, 7, 6), 0, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0),
           1'($urandom_range(0, 1)),
           A'($urandom_range(0, D-1)),
           W'($urandom),
           (N*A)'($urandom),
           1'($urandom_range(0, 1)),
           A'($urandom_range(0, D-1)));
    end

    // drain
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain queue_left=%0d exp=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised MIPS general-purpose register file with multi-port combinational read, single write port, hardwired-zero register 0 and a per-register busy scoreboard. It sits between decode (read/issue) and writeback in the single-cycle/pipelined datapath. It replaces the fixed 32x32, two-read-port register file. Width, depth and read-port count are configurable. It adds reset clearing and optional write-to-read bypass.

## Interface
- `WIDTH`, 32, data bits per register
- `DEPTH`, 32, number of registers; power of two, >= 2
- `NUM_RD`, 2, number of read ports (1..4)
- `AW`, $clog2(DEPTH), address width (derived, not overridden)

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `regW`  in  1  write enable for writeback port
- `DR`  in  AW  writeback destination register
- `regIn`  in  WIDTH  writeback data
- `rd_addr`  in  NUM_RD*AW  read addresses; port i at bits [i*AW +: AW]
- `rd_data`  out  NUM_RD*WIDTH  read data; port i at bits [i*WIDTH +: WIDTH]
- `rd_busy`  out  NUM_RD  busy flag of register addressed by port i
- `iss_valid`  in  1  an instruction issues that will later write `iss_dr`
- `iss_dr`  in  AW  destination of issuing instruction

## Operation
- Storage: DEPTH x WIDTH flops; register 0 reads as 0 always, never written, never busy.
- Write: on rising clk with `regW`=1 and `DR`!=0, reg[DR] <= regIn. `DR`=0 write silently dropped.
- Read: fully combinational; rd_data[i] = reg[rd_addr[i]] (0 for address 0). All ports independent; identical addresses on several ports legal.
- Scoreboard: busy[DEPTH] bits.
  - Set: `iss_valid`=1 and `iss_dr`!=0 -> busy[iss_dr] <= 1 at next edge.
  - Clear: `regW`=1 and `DR`!=0 -> busy[DR] <= 0 at next edge.
  - Same register set and cleared in same cycle: set wins (newer producer outstanding).
  - Different registers: both take effect.
  - Set of an already-busy register: stays 1; no counting (one outstanding producer per register).
- rd_busy[i] = busy[rd_addr[i]]; 0 for address 0.
- Out-of-range addresses impossible (DEPTH power of two).

## Timing
- Reset (rst_n low, asynchronous, any time incl. mid-write): all registers 0, all busy 0; rd_data all 0 and rd_busy all 0 combinationally while in reset; writes/issues ignored. Deassertion synchronous-safe: first write takes effect at first rising edge with rst_n high.
- Write latency: 1 edge; without bypass, new value visible on rd_data in the cycle after the edge.
- Scoreboard latency: busy visible on rd_busy the cycle after the set/clear edge.
- No handshakes; every cycle accepts one write and one issue.

## Configuration
- `REGFILE_BYPASS_EN` defined: when `regW`=1, `DR`!=0 and rd_addr[i]==DR, rd_data[i]=regIn and rd_busy[i]=0 in the same cycle (write-before-read within cycle), unless the same register is also being set busy by `iss_valid`/`iss_dr` — busy output still forced 0 for that cycle (reflects data, not pending producer).
- Undefined: rd_data/rd_busy reflect stored state only; reader in same cycle as write sees old value and busy=1.

## Structure
- Shared package `mips_pkg`: default WIDTH/DEPTH constants, `reg_addr_t` and `word_t` typedefs, `REG_ZERO` constant.
- One sub-module natural: `regfile_scoreboard` (busy vector, set/clear priority, per-port lookup); data array and read muxes stay in the top.

## Test plan
- Reset: drive rst_n=0 mid-run after writing reg 5=0x1234 -> rd_data for addr 5 = 0, all rd_busy = 0 immediately; stays 0 after release.
- Write/read: regW=1, DR=1, regIn=200; next cycle rd_addr port1=1 -> 200; port0=0 -> 0; DR=0, regIn=5 write -> reg 0 still reads 0.
- Multi-port: NUM_RD=4, write regs 3,7 = 0xA,0xB; ports addr {3,7,3,0} -> {0xA,0xB,0xA,0}.
- Scoreboard: iss_valid, iss_dr=9 -> next cycle rd_busy=1 on port reading 9; writeback DR=9 -> busy 0 the cycle after; same-cycle iss_dr=9 and DR=9 -> busy stays 1.
- Bypass (with `REGFILE_BYPASS_EN`): reg 4=7 busy; regW, DR=4, regIn=99, rd_addr=4 -> same cycle rd_data=99, rd_busy=0; without macro -> 7 and 1, then 99 and 0 next cycle.
- Parameters: WIDTH=16, DEPTH=8 -> write 0xFFFF to reg 7, read back 0xFFFF; reg 0 write ignored.
